fft_out_reorder: RTL and testbench

//  Sink for the FFT controller's result stream. Captures each N-point frame driven with out_vld (no backpressure),

---
 rtl/fft_out_reorder.sv | 142 ++++++++++++++
 tb/tb_fft_out_reorder.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/fft_out_reorder.sv
// FFT result sink: captures N-point frames into a ping-pong buffer and replays them
// downstream in natural bin order over a valid/ready interface.
module fft_out_reorder #(
  parameter int N       = 16,
  parameter int LOGN    = 4,
  parameter int DW      = 16,
  parameter int REORDER = 1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            s_vld,
  input  logic [DW-1:0]   s_re,
  input  logic [DW-1:0]   s_im,
  output logic            m_vld,
  input  logic            m_rdy,
  output logic [DW-1:0]   m_re,
  output logic [DW-1:0]   m_im,
  output logic [LOGN-1:0] m_idx,
  output logic            m_last,
  output logic            overflow
);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} rd_state_t;

  logic [2*DW-1:0] mem [2][N];

  logic [1:0]      full;
  logic            wr_bank, rd_bank;
  logic [LOGN-1:0] wr_cnt, rd_cnt;
  logic            drop;
  rd_state_t       state;

  function automatic logic [LOGN-1:0] bitrev(input logic [LOGN-1:0] v);
    logic [LOGN-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < LOGN; i++) r[i] = v[LOGN-1-i];
    return r;
  endfunction

  // Write side: drop decision is taken from the registered full flag at frame start.
  logic            wr_first, wr_drop, wr_en, wr_done;
  logic [LOGN-1:0] wr_addr;
  logic [1:0]      full_set;

  always_comb begin
    wr_first = (wr_cnt == '0);
    wr_drop  = wr_first ? full[wr_bank] : drop;
    wr_en    = s_vld && !wr_drop;
    wr_done  = wr_en && (wr_cnt == LOGN'(N-1));
    wr_addr  = (REORDER != 0) ? bitrev(wr_cnt) : wr_cnt;
    full_set = '0;
    if (wr_done) full_set[wr_bank] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_bank][wr_addr] <= {s_re, s_im};
  end

  // Read side: in DRAIN the last bin is waiting for its handshake; on that edge the
  // other bank's bin 0 can be loaded straight away so frames stream without a bubble.
  logic            hs, can_load, ld_en, ld_bank;
  logic [LOGN-1:0] ld_idx;
  logic [1:0]      full_clr;
  logic [2*DW-1:0] rd_data;

  always_comb begin
    hs       = m_vld && m_rdy;
    can_load = !m_vld || m_rdy;
    ld_en    = 1'b0;
    ld_bank  = rd_bank;
    ld_idx   = '0;
    full_clr = '0;
    case (state)
      IDLE:   ld_en = full[rd_bank] && can_load;
      STREAM: begin
        ld_en  = can_load;
        ld_idx = rd_cnt;
      end
      DRAIN: begin
        ld_bank = ~rd_bank;
        if (hs) begin
          full_clr[rd_bank] = 1'b1;
          ld_en             = full[~rd_bank];
        end
      end
      default: ;
    endcase
    rd_data = mem[ld_bank][ld_idx];
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      full     <= '0;
      wr_bank  <= 1'b0;
      wr_cnt   <= '0;
      drop     <= 1'b0;
      overflow <= 1'b0;
      state    <= IDLE;
      rd_bank  <= 1'b0;
      rd_cnt   <= '0;
      m_vld    <= 1'b0;
      m_re     <= '0;
      m_im     <= '0;
      m_idx    <= '0;
      m_last   <= 1'b0;
    end else begin
      full <= (full | full_set) & ~full_clr;

      if (s_vld) begin
        wr_cnt <= wr_cnt + 1'b1;
        if (wr_first) begin
          drop <= full[wr_bank];
          if (full[wr_bank]) overflow <= 1'b1;
        end
        if (wr_done) wr_bank <= ~wr_bank;
      end

      if (state == DRAIN && hs) begin
        rd_bank <= ~rd_bank;
        if (!ld_en) state <= IDLE;
      end

      if (ld_en) begin
        m_vld  <= 1'b1;
        m_re   <= rd_data[2*DW-1:DW];
        m_im   <= rd_data[DW-1:0];
        m_idx  <= ld_idx;
        m_last <= (ld_idx == LOGN'(N-1));
        if (ld_idx == LOGN'(N-1)) begin
          rd_cnt <= '0;
          state  <= DRAIN;
        end else begin
          rd_cnt <= ld_idx + 1'b1;
          state  <= STREAM;
        end
      end else if (hs) begin
        m_vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fft_out_reorder.sv
// Scoreboard bench for fft_out_reorder: one bit-reversing and one pass-through instance
// share stimulus; a forked monitor pops expected bins on every output handshake.
module tb_fft_out_reorder;

  localparam int N    = 16;
  localparam int LOGN = 4;
  localparam int DW   = 16;

  typedef struct packed {
    logic [DW-1:0]   re;
    logic [DW-1:0]   im;
    logic [LOGN-1:0] idx;
    logic            last;
  } exp_t;

  logic            clk, rstn, s_vld, m_rdy;
  logic [DW-1:0]   s_re, s_im;
  logic            m_vld, m_last, overflow;
  logic [DW-1:0]   m_re, m_im;
  logic [LOGN-1:0] m_idx;
  logic            n_vld, n_last, n_overflow;
  logic [DW-1:0]   n_re, n_im;
  logic [LOGN-1:0] n_idx;

  exp_t q_rev[$];
  exp_t q_nat[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   brt [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

  fft_out_reorder #(.N(N), .LOGN(LOGN), .DW(DW), .REORDER(1)) dut (
    .clk(clk), .rstn(rstn), .s_vld(s_vld), .s_re(s_re), .s_im(s_im),
    .m_vld(m_vld), .m_rdy(m_rdy), .m_re(m_re), .m_im(m_im),
    .m_idx(m_idx), .m_last(m_last), .overflow(overflow)
  );

  fft_out_reorder #(.N(N), .LOGN(LOGN), .DW(DW), .REORDER(0)) dut_nat (
    .clk(clk), .rstn(rstn), .s_vld(s_vld), .s_re(s_re), .s_im(s_im),
    .m_vld(n_vld), .m_rdy(m_rdy), .m_re(n_re), .m_im(n_im),
    .m_idx(n_idx), .m_last(n_last), .overflow(n_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
    s_vld = 1'b0;
  endtask

  // Sample k of a frame carries re = base+k, im = -(base+k).
  task automatic send_frame(input int base, input int gap_max, input bit exp_drop);
    logic [DW-1:0] v;
    if (!exp_drop) begin
      for (int i = 0; i < N; i++) begin
        v = DW'(base + brt[i]);
        q_rev.push_back('{re: v, im: -v, idx: LOGN'(i), last: (i == N-1)});
        v = DW'(base + i);
        q_nat.push_back('{re: v, im: -v, idx: LOGN'(i), last: (i == N-1)});
      end
    end
    for (int k = 0; k < N; k++) begin
      if (gap_max > 0) repeat ($urandom_range(3, gap_max)) idle();
      @(posedge clk); #1;
      v     = DW'(base + k);
      s_vld = 1'b1;
      s_re  = v;
      s_im  = -v;
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    s_vld = 1'b0;
    q_rev.delete();
    q_nat.delete();
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  task automatic wait_drain(input int budget);
    int t = 0;
    while ((q_rev.size() != 0 || q_nat.size() != 0) && t < budget) begin
      @(posedge clk); #1;
      t++;
    end
    check("drain_timeout", 64'(q_rev.size() + q_nat.size()), 64'd0);
  endtask

  task automatic monitor();
    logic [37:0] prev;
    logic        prev_ok, prev_stall;
    exp_t        e;
    prev_ok = 1'b0;
    prev_stall = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      if (rstn && prev_ok && prev_stall)
        check("hold_stable", 64'({m_vld, m_re, m_im, m_idx, m_last}), 64'(prev));
      if (rstn && m_vld && m_rdy) begin
        if (q_rev.size() == 0) check("unexpected_rev", 64'({m_re, m_im, m_idx, m_last}), 64'd0);
        else begin
          e = q_rev.pop_front();
          check("out_rev", 64'({m_re, m_im, m_idx, m_last}), 64'(e));
        end
      end
      if (rstn && n_vld && m_rdy) begin
        if (q_nat.size() == 0) check("unexpected_nat", 64'({n_re, n_im, n_idx, n_last}), 64'd0);
        else begin
          e = q_nat.pop_front();
          check("out_nat", 64'({n_re, n_im, n_idx, n_last}), 64'(e));
        end
      end
      prev_ok    = rstn;
      prev_stall = m_vld && !m_rdy;
      prev       = {m_vld, m_re, m_im, m_idx, m_last};
    end
  endtask

  initial begin
    int  cnt;
    int  t;
    bit  found;
    rstn = 1'b0; s_vld = 1'b0; s_re = '0; s_im = '0; m_rdy = 1'b1;
    fork monitor(); join_none
    do_reset();
    check("reset_outputs", 64'({m_vld, m_re, m_im, m_idx, m_last, overflow}), 64'd0);
    check("reset_outputs_nat", 64'({n_vld, n_re, n_im, n_idx, n_last, n_overflow}), 64'd0);

    // Single frame, bit-reversed order and first-output latency
    send_frame(0, 0, 0);
    idle();
    check("latency_not_yet", 64'(m_vld), 64'd0);
    @(posedge clk); #1;
    check("latency_first", 64'({m_vld, m_idx}), 64'({1'b1, 4'd0}));
    wait_drain(40);

    // Two back-to-back frames stream with no gap between them
    fork
      begin
        send_frame(32, 0, 0);
        send_frame(64, 0, 0);
        idle();
      end
      begin
        t = 0;
        while (!m_vld && t < 100) begin @(posedge clk); #2; t++; end
        cnt = 0;
        repeat (32) begin
          cnt += int'(m_vld);
          @(posedge clk); #2;
        end
        check("no_gap_32", 64'(cnt), 64'd32);
      end
    join
    wait_drain(40);
    check("overflow_clear", 64'(overflow), 64'd0);

    // Stalled consumer: third frame is dropped, first two survive
    m_rdy = 1'b0;
    send_frame(96, 0, 0);
    send_frame(128, 0, 0);
    send_frame(160, 0, 1);
    repeat (3) idle();
    check("overflow_set", 64'({overflow, n_overflow}), 64'b11);
    check("stall_head", 64'({m_vld, m_idx, m_re}), 64'({1'b1, 4'd0, 16'd96}));
    repeat (5) idle();
    m_rdy = 1'b1;
    wait_drain(80);
    repeat (20) idle();
    check("stall_drained", 64'(m_vld), 64'd0);

    do_reset();
    check("overflow_reset", 64'(overflow), 64'd0);

    // Random ready with gapped input
    fork
      begin
        for (int f = 1; f <= 3; f++) send_frame(f * 256, 5, 0);
        idle();
      end
      begin
        repeat (300) begin
          @(posedge clk); #1;
          m_rdy = 1'($urandom_range(0, 1));
        end
        m_rdy = 1'b1;
      end
    join
    wait_drain(100);
    check("random_no_overflow", 64'(overflow), 64'd0);

    // Reset in the middle of an output frame
    send_frame(16'h700, 0, 0);
    idle();
    found = 1'b0;
    t = 0;
    while (!found && t < 40) begin
      @(posedge clk); #1;
      found = m_vld && (m_idx == 4'd5);
      t++;
    end
    check("reach_bin5", 64'(found), 64'd1);
    @(posedge clk); #1;
    rstn = 1'b0;
    q_rev.delete();
    q_nat.delete();
    @(posedge clk); #1;
    check("midreset_outputs", 64'({m_vld, m_re, m_im, m_idx, m_last, overflow}), 64'd0);
    rstn = 1'b1;
    send_frame(16'h800, 0, 0);
    idle();
    wait_drain(60);
    repeat (5) idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
